qpsk_slicer_packer: RTL and testbench
=====================================

Name: qpsk_slicer_packer

Overview:
- Sits directly downstream of the keep-one-in-N decimator in the QPSK receive chain and consumes its decimated IQ stream.
- Hard-slices each IQ sample to a 2-bit QPSK symbol by sign.
- Packs SYMS_PER_WORD symbols into one output word for the bit-level stages that follow.
- Packet boundaries (tlast) are preserved. A partial word is flushed on tlast, with its symbol count on o_tuser.

Parameters:
- WIDTH, 32, input sample width; I = i_tdata[WIDTH-1:WIDTH/2], Q = i_tdata[WIDTH/2-1:0], both two's complement.
- SYMS_PER_WORD, 16, symbols per output word; output width = 2*SYMS_PER_WORD. Legal range 2..64.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_tdata  in  WIDTH  decimated IQ sample.
- i_tlast  in  1  last sample of packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  2*SYMS_PER_WORD  packed symbols; first-received symbol in MSBs.
- o_tuser  out  $clog2(SYMS_PER_WORD+1)  number of valid symbols in o_tdata (1..SYMS_PER_WORD).
- o_tlast  out  1  word contains the packet's last symbol.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- On reset assertion, cleared immediately and independent of clk:
  - o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0.
  - Fill counter=0, accumulator=0.
- Slicing (combinational on i_tdata):
  - sym[1] = I sign bit. sym[0] = Q sign bit.
  - Zero counts as non-negative (bit 0).
  - Mapping: 00 = (+,+), 01 = (+,-), 10 = (-,+), 11 = (-,-).
- Symbol placement:
  - Symbol k (k = 0..SYMS_PER_WORD-1, in arrival order) occupies o_tdata[2*(SYMS_PER_WORD-1-k)+1 : 2*(SYMS_PER_WORD-1-k)].
  - Unused slots in a partial word are 0.
- Storage:
  - Accumulator register of 2*SYMS_PER_WORD bits.
  - Fill counter 0..SYMS_PER_WORD-1.
  - One-deep output register holding o_tdata, o_tuser and o_tlast.
- Handshake:
  - i_tready = ~o_tvalid | o_tready (combinational; no path from i_tvalid).
  - Accept = i_tvalid & i_tready.
  - An output transfer occurs when o_tvalid & o_tready.
- FSM, two states (ACCUM, HOLD); HOLD is equivalent to o_tvalid=1.
  - ACCUM, accept without completion (fill < SYMS_PER_WORD-1 and ~i_tlast): insert symbol at slot fill, fill+1.
  - Completion = accept with (fill == SYMS_PER_WORD-1) or i_tlast.
    - Next cycle: output register = accumulator with the new symbol merged in.
    - o_tuser = fill+1, o_tlast = i_tlast, o_tvalid = 1.
    - Accumulator cleared, fill = 0.
  - HOLD, output transfer with no completing accept in the same cycle: o_tvalid -> 0.
  - HOLD, output transfer together with a completing accept: output register reloads with the new word and o_tvalid stays 1. This gives back-to-back words with no bubble.
  - HOLD, o_tready=0: o_tdata, o_tuser and o_tlast held stable; i_tready=0.
- Latency and throughput:
  - Latency is 1 cycle from the completing input beat to o_tvalid.
  - Sustained throughput is 1 sample/cycle when o_tready=1.
- Boundary cases:
  - tlast on slot SYMS_PER_WORD-1: single word, o_tuser = SYMS_PER_WORD, o_tlast = 1. No extra empty word is emitted.
  - tlast on slot 0: o_tuser = 1.
  - Empty words are never generated.
  - Accumulator contents while in HOLD: new symbols may accept into the accumulator only through i_tready. Because i_tready = ~o_tvalid | o_tready, the accumulator never overflows and no sample is dropped.
  - Input is never stalled while o_tvalid=0.
- Reset mid-operation: any partial word and any held output are discarded. The first accepted sample after release lands in slot 0.
- Protocol assumptions:
  - i_tdata and i_tlast are sampled only on accept.
  - o_tvalid never deasserts without a transfer; output fields never change while o_tvalid & ~o_tready.

Test Plan:
- 16 samples, I=+1000, Q=-1000, o_tready=1, tlast on 16th -> one word: o_tdata=0x55555555, o_tuser=16, o_tlast=1, appearing 1 cycle after 16th accept.
- 32 samples cycling (+,+), (+,-), (-,+), (-,-), no tlast -> two words of 0x1B1B1B1B, o_tuser=16, o_tlast=0, back-to-back with i_tready=1 throughout.
- 3 samples (-,-) with tlast on 3rd -> o_tdata=0xFC000000, o_tuser=3, o_tlast=1. A following packet of 1 sample (+,-) with tlast -> o_tdata=0x40000000, o_tuser=1.
- I=0, Q=0 and I=-1, Q=0 as first two of a 2-sample tlast packet -> o_tdata=0x20000000, o_tuser=2 (zero treated as positive).
- Word ready, o_tready held 0 for 10 cycles with i_tvalid=1 -> o_tvalid=1, o_tdata stable, i_tready=0 for all 10 cycles. On o_tready=1, transfer occurs and input resumes with no sample lost; check the total symbol count.
- After 5 accepted samples, pulse reset_n low mid-cycle -> o_tvalid=0 immediately. The next 16 samples of (-,+) yield exactly 0xAAAAAAAA, o_tuser=16, with no residue from before reset.

Source files
------------

// File: rtl/qpsk_slicer_packer.sv
// QPSK hard slicer and symbol packer: slices each IQ sample by sign into a 2-bit
// symbol and packs SYMS_PER_WORD symbols per output word, flushing partial words on tlast.
module qpsk_slicer_packer #(
    parameter int WIDTH         = 32,
    parameter int SYMS_PER_WORD = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [WIDTH-1:0]                       i_tdata,
    input  logic                                   i_tlast,
    input  logic                                   i_tvalid,
    output logic                                   i_tready,
    output logic [2*SYMS_PER_WORD-1:0]             o_tdata,
    output logic [$clog2(SYMS_PER_WORD+1)-1:0]     o_tuser,
    output logic                                   o_tlast,
    output logic                                   o_tvalid,
    input  logic                                   o_tready
);

    localparam int OW = 2 * SYMS_PER_WORD;
    localparam int UW = $clog2(SYMS_PER_WORD + 1);
    localparam int CW = $clog2(SYMS_PER_WORD);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [OW-1:0]   data_q, data_d;
    logic [UW-1:0]   user_q, user_d;
    logic            last_q, last_d;

    logic [1:0]      sym;
    logic [OW-1:0]   merged;
    logic            accept;
    logic            complete;
    logic            out_xfer;

    // Sign bits of I (upper half) and Q (lower half); zero slices as non-negative.
    function automatic logic [1:0] slice(input logic [WIDTH-1:0] sample);
        return {sample[WIDTH-1], sample[WIDTH/2-1]};
    endfunction

    // First-arrived symbol sits in the MSBs, so slot k maps to bit pair SYMS_PER_WORD-1-k.
    function automatic logic [OW-1:0] place(input logic [OW-1:0] word,
                                            input logic [CW-1:0] slot,
                                            input logic [1:0]    s);
        logic [OW-1:0] w;
        w = word;
        for (int k = 0; k < SYMS_PER_WORD; k++) begin
            if (slot == CW'(k)) begin
                w[2*(SYMS_PER_WORD-1-k) +: 2] = s;
            end
        end
        return w;
    endfunction

    assign o_tvalid = (state_q == HOLD);
    assign o_tdata  = data_q;
    assign o_tuser  = user_q;
    assign o_tlast  = last_q;

    assign i_tready = ~o_tvalid | o_tready;
    assign accept   = i_tvalid & i_tready;
    assign out_xfer = o_tvalid & o_tready;
    assign complete = accept & ((fill_q == CW'(SYMS_PER_WORD - 1)) | i_tlast);

    assign sym      = slice(i_tdata);
    assign merged   = place(acc_q, fill_q, sym);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;

        if (accept) begin
            if (complete) begin
                acc_d  = '0;
                fill_d = '0;
            end else begin
                acc_d  = merged;
                fill_d = fill_q + CW'(1);
            end
        end

        // A completing beat reloads the output register even while the previous
        // word is leaving, which keeps back-to-back words bubble-free.
        if (complete) begin
            state_d = HOLD;
            data_d  = merged;
            user_d  = UW'(fill_q) + UW'(1);
            last_d  = i_tlast;
        end else if (out_xfer) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_qpsk_slicer_packer.sv
// Self-checking bench for qpsk_slicer_packer: directed sequences, a slicing vector
// table and randomized traffic checked against a queue-based packet model.
module tb_qpsk_slicer_packer;

    localparam int W   = 32;
    localparam int SPW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  i_tdata;
    logic          i_tlast;
    logic          i_tvalid;
    logic          i_tready;
    logic [31:0]   o_tdata;
    logic [4:0]    o_tuser;
    logic          o_tlast;
    logic          o_tvalid;
    logic          o_tready;

    qpsk_slicer_packer #(.WIDTH(W), .SYMS_PER_WORD(SPW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tuser  (o_tuser),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  u;
        logic        l;
        int          xe;
    } word_t;

    typedef struct {
        int         i;
        int         q;
        logic [1:0] sym;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         last_acc_edge = 0;
    bit         rand_ready = 0;
    word_t      exp_q[$];
    word_t      got[$];
    logic [1:0] cur_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [63:0] wv(input logic [31:0] d, input logic [4:0] u, input logic l);
        return {26'b0, l, u, d};
    endfunction

    function automatic logic [31:0] mk(input int i, input int q);
        logic [15:0] a, b;
        a = i[15:0];
        b = q[15:0];
        return {a, b};
    endfunction

    // Reference model: symbols collected per packet, emitted as a word every SPW symbols or on tlast.
    task automatic model_push(input logic [31:0] d, input logic l);
        logic signed [15:0] iv, qv;
        logic [31:0]        w;
        word_t              e;
        iv = d[31:16];
        qv = d[15:0];
        cur_q.push_back({iv < 0, qv < 0});
        if (cur_q.size() == SPW || l) begin
            w = 0;
            for (int k = 0; k < cur_q.size(); k++) w = w | (32'(cur_q[k]) << (2 * (SPW - 1 - k)));
            e.d = w; e.u = 5'(cur_q.size()); e.l = l; e.xe = 0;
            exp_q.push_back(e);
            cur_q.delete();
        end
    endtask

    // Monitor runs mid low-phase, when the inputs for the coming edge are settled.
    logic        hold_prev = 0;
    logic [63:0] hold_val;
    always @(negedge clk) begin
        word_t g, e;
        #2;
        if (!reset_n) begin
            hold_prev = 0;
        end else begin
            if (hold_prev) chk("hold_stable", {31'b0, o_tvalid, wv(o_tdata, o_tuser, o_tlast)[31:0]} | (wv(o_tdata, o_tuser, o_tlast) & 64'hFFFFFFFF_00000000),
                               {31'b0, 1'b1, hold_val[31:0]} | (hold_val & 64'hFFFFFFFF_00000000));
            if (o_tvalid && o_tready) begin
                g.d = o_tdata; g.u = o_tuser; g.l = o_tlast; g.xe = cyc + 1;
                got.push_back(g);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", wv(g.d, g.u, g.l), 64'hFFFFFFFF_FFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("model_word", wv(g.d, g.u, g.l), wv(e.d, e.u, e.l));
                end
            end
            hold_prev = o_tvalid && !o_tready;
            hold_val  = wv(o_tdata, o_tuser, o_tlast);
        end
    end

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send(input logic [31:0] d, input logic l, output int stalls);
        int   n;
        logic acc;
        n = 0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        do begin
            #1 acc = i_tready;
            @(negedge clk);
            if (!acc) n++;
        end while (!acc && n < 200);
        i_tvalid = 1'b0;
        if (!acc) chk("accept_timeout", 64'(n), 64'd0);
        else begin
            model_push(d, l);
            last_acc_edge = cyc;
        end
        stalls = n;
    endtask

    task automatic drain();
        int n;
        n = 0;
        o_tready = 1'b1;
        while ((exp_q.size() != 0 || o_tvalid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [31:0] d,
                           input logic [4:0] u, input logic l);
        if (idx >= got.size()) chk({nm, "_missing"}, 64'(got.size()), 64'(idx + 1));
        else chk(nm, wv(got[idx].d, got[idx].u, got[idx].l), wv(d, u, l));
    endtask

    task automatic pulse_reset(input logic pre_valid);
        #1 chk("pre_reset_valid", 64'(o_tvalid), 64'(pre_valid));
        #2 reset_n = 1'b0;
        #1 chk("reset_async_out", 64'({o_tvalid, o_tlast, o_tuser, o_tdata}), 64'd0);
        chk("reset_ready", 64'(i_tready), 64'd1);
        @(negedge clk);
        #3 reset_n = 1'b1;
        exp_q.delete();
        cur_q.delete();
        @(negedge clk);
    endtask

    function automatic int sum_syms(input int base);
        int s;
        s = 0;
        for (int k = base; k < got.size(); k++) s += int'(got[k].u);
        return s;
    endfunction

    initial begin
        vec_t tbl[8];
        int   st, stot, base, acc_e, nsym;
        logic [31:0] x;

        tbl[0] = '{i: 0,      q: 0,      sym: 2'b00};
        tbl[1] = '{i: -1,     q: 0,      sym: 2'b10};
        tbl[2] = '{i: 1000,   q: -1000,  sym: 2'b01};
        tbl[3] = '{i: 32767,  q: -32768, sym: 2'b01};
        tbl[4] = '{i: -32768, q: -32768, sym: 2'b11};
        tbl[5] = '{i: -1,     q: -1,     sym: 2'b11};
        tbl[6] = '{i: 1,      q: 0,      sym: 2'b00};
        tbl[7] = '{i: 0,      q: -1,     sym: 2'b01};

        reset_n = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        @(negedge clk);
        #1 chk("reset_state", 64'({o_tvalid, o_tlast, o_tuser, o_tdata}), 64'd0);
        chk("reset_ready", 64'(i_tready), 64'd1);
        @(negedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);

        // Full word with tlast on the last slot; output one edge after the completing accept.
        base = got.size();
        for (int k = 0; k < SPW; k++) send(mk(1000, -1000), k == SPW - 1, st);
        acc_e = last_acc_edge;
        drain();
        chk_got("t1_word", base, 32'h55555555, 5'd16, 1'b1);
        chk("t1_count", 64'(got.size() - base), 64'd1);
        if (got.size() > base) chk("t1_latency", 64'(got[base].xe - acc_e), 64'd1);

        // Two back-to-back full words with no input stall.
        base = got.size(); stot = 0;
        for (int k = 0; k < 2 * SPW; k++) begin
            send(mk((k % 4) >= 2 ? -500 : 500, (k % 2) ? -500 : 500), 1'b0, st);
            stot += st;
        end
        drain();
        chk_got("t2_word0", base, 32'h1B1B1B1B, 5'd16, 1'b0);
        chk_got("t2_word1", base + 1, 32'h1B1B1B1B, 5'd16, 1'b0);
        chk("t2_no_stall", 64'(stot), 64'd0);
        if (got.size() > base + 1) chk("t2_spacing", 64'(got[base+1].xe - got[base].xe), 64'(SPW));

        // Short packets: partial words flushed on tlast.
        base = got.size();
        for (int k = 0; k < 3; k++) send(mk(-7, -7), k == 2, st);
        send(mk(7, -7), 1'b1, st);
        send(mk(0, 0), 1'b0, st);
        send(mk(-1, 0), 1'b1, st);
        drain();
        chk_got("t3_three", base, 32'hFC000000, 5'd3, 1'b1);
        chk_got("t3_single", base + 1, 32'h40000000, 5'd1, 1'b1);
        chk_got("t4_zero_pos", base + 2, 32'h20000000, 5'd2, 1'b1);

        // Downstream stall with a word held and input pending.
        base = got.size();
        o_tready = 1'b0;
        for (int k = 0; k < SPW; k++) send(mk((k % 2) ? -3 : 3, (k % 2) ? 3 : -3), 1'b0, st);
        x = mk(3, -3);
        i_tdata = x; i_tlast = 1'b0; i_tvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1 chk("t5_stall", 64'({o_tvalid, i_tready, o_tdata}), 64'({1'b1, 1'b0, 32'h66666666}));
            @(negedge clk);
        end
        o_tready = 1'b1;
        send(x, 1'b0, st);
        for (int k = 1; k < 8; k++) send(mk((k % 2) ? -3 : 3, (k % 2) ? 3 : -3), k == 7, st);
        drain();
        chk_got("t5_word0", base, 32'h66666666, 5'd16, 1'b0);
        chk_got("t5_word1", base + 1, 32'h66660000, 5'd8, 1'b1);
        chk("t5_symbols", 64'(sum_syms(base)), 64'd24);

        // Reset with a held output word, then with a partial accumulator.
        for (int k = 0; k < 4; k++) send(mk(5, 5), 1'b0, st);
        o_tready = 1'b0;
        send(mk(5, 5), 1'b1, st);
        pulse_reset(1'b1);
        o_tready = 1'b1;
        for (int k = 0; k < 5; k++) send(mk(5, 5), 1'b0, st);
        pulse_reset(1'b0);
        base = got.size();
        for (int k = 0; k < SPW; k++) send(mk(-9, 9), 1'b0, st);
        drain();
        chk_got("t6_after_reset", base, 32'hAAAAAAAA, 5'd16, 1'b0);
        chk("t6_count", 64'(got.size() - base), 64'd1);

        // Slicing table: each entry sent as a one-sample packet.
        for (int k = 0; k < 8; k++) begin
            base = got.size();
            send(mk(tbl[k].i, tbl[k].q), 1'b1, st);
            drain();
            chk_got($sformatf("table_%0d", k), base, {tbl[k].sym, 30'b0}, 5'd1, 1'b1);
        end

        // Randomized traffic with random backpressure.
        base = got.size(); nsym = 0;
        rand_ready = 1;
        for (int k = 0; k < 400; k++) begin
            int a, b, r;
            r = $urandom_range(0, 3);
            a = (r == 0) ? 0 : (r == 1) ? -1 : int'($urandom_range(0, 65535));
            r = $urandom_range(0, 3);
            b = (r == 0) ? 0 : (r == 1) ? -1 : int'($urandom_range(0, 65535));
            send(mk(a, b), (k == 399) || ($urandom_range(0, 7) == 0), st);
            nsym++;
        end
        rand_ready = 0;
        drain();
        chk("rand_symbols", 64'(sum_syms(base)), 64'(nsym));
        chk("rand_model_empty", 64'(exp_q.size() + cur_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
